// File: rtl/gsensor_spi_responder.sv
`timescale 1ns/1ps
// SPI mode-3 responder emulating the accelerometer's 64 x 8 register file; SPI pads oversampled on i_clk.
// Define GSENSOR_SPI_3WIRE_EN for 3-wire use (SDO enabled only during read data bytes).
module gsensor_spi_responder #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] DEVID_VALUE  = 8'hE5,
  parameter int         SCLK_MAX_DIV = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_sclk,
  input  logic       i_spi_sdi,
  output logic       o_spi_sdo,
  output logic       o_spi_sdo_oe,
  input  logic       i_reg_wr_en,
  input  logic [5:0] i_reg_wr_addr,
  input  logic [7:0] i_reg_wr_data,
  output logic       o_rx_valid,
  output logic [5:0] o_rx_addr,
  output logic [7:0] o_rx_data,
  output logic       o_busy
);

  // Each SCLK half period must cover synchronizer, edge detect and SDO update.
  if (SYNC_STAGES < 2 || SCLK_MAX_DIV < 2 * (SYNC_STAGES + 2)) begin : g_param_check
    $error("gsensor_spi_responder: SYNC_STAGES/SCLK_MAX_DIV out of range");
  end

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync, flush;
  logic       cs_s, sclk_s, sdi_s, cs_d, sclk_d, armed;
  logic       sclk_rise, sclk_fall, cs_fall;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] tx, rx_byte;
  logic       rd, mb, done;
  logic [5:0] addr;
  logic       shift_in, shift_out, cmd_done, data_done, spi_we, fab_we;
  logic [7:0] regs [0:63];

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;
  // armed blocks a frame already in progress when reset released from starting mid-way
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign rx_byte   = {shreg, sdi_s};
  assign spi_we    = data_done & ~rd & ~done & (addr != 6'd0);
  assign fab_we    = i_reg_wr_en & (i_reg_wr_addr != 6'd0) & ~(spi_we & (i_reg_wr_addr == addr));
  assign o_busy    = ~cs_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = CMD;
      CMD:     if (cs_s) state_nxt = IDLE; else if (cmd_done) state_nxt = DATA;
      DATA:    if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_in  = 1'b0;
    shift_out = 1'b0;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    case (state)
      CMD: begin
        shift_in = sclk_rise & ~cs_s;
        cmd_done = shift_in & (bit_cnt == 3'd7);
      end
      DATA: begin
        shift_in  = sclk_rise & ~cs_s;
        data_done = shift_in & (bit_cnt == 3'd7);
        shift_out = sclk_fall & rd & ~cs_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_sync <= '1; sclk_sync <= '1; sdi_sync <= '0; flush <= '0;
      cs_d <= 1'b1; sclk_d <= 1'b1; armed <= 1'b0;
      bit_cnt <= 3'd0; shreg <= 7'd0; tx <= 8'd0;
      rd <= 1'b0; mb <= 1'b0; done <= 1'b0; addr <= 6'd0;
      o_spi_sdo <= 1'b0; o_rx_valid <= 1'b0; o_rx_addr <= 6'd0; o_rx_data <= 8'd0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], i_spi_sdi};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
      if (flush[SYNC_STAGES-1] & cs_s) armed <= 1'b1;

      o_rx_valid <= spi_we;
      if (spi_we) begin
        o_rx_addr <= addr;
        o_rx_data <= rx_byte;
      end

      if (state == IDLE) bit_cnt <= 3'd0;
      else if (shift_in) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= rx_byte[6:0];
      end

      if (cmd_done) begin
        rd   <= rx_byte[7];
        mb   <= rx_byte[6];
        addr <= rx_byte[5:0];
        done <= 1'b0;
        tx   <= rx_byte[7] ? regs[rx_byte[5:0]] : 8'h00;
      end else if (data_done) begin
        if (mb) addr <= addr + 6'd1;
        else    done <= 1'b1;
        tx <= (rd & mb) ? regs[addr + 6'd1] : 8'h00;
      end else if (shift_out) begin
        tx <= {tx[6:0], 1'b0};
      end

      if (shift_out) o_spi_sdo <= tx[7];
      else if (state != DATA || data_done || cs_s) o_spi_sdo <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 64; i++) regs[i] <= (i == 0) ? DEVID_VALUE : 8'h00;
    end else begin
      if (fab_we) regs[i_reg_wr_addr] <= i_reg_wr_data;
      if (spi_we) regs[addr] <= rx_byte;
    end
  end

`ifdef GSENSOR_SPI_3WIRE_EN
  logic sdo_oe;
  always_ff @(posedge i_clk) begin
    if (i_rst) sdo_oe <= 1'b0;
    else if (cs_s || state == IDLE) sdo_oe <= 1'b0;
    else if (cmd_done & rx_byte[7]) sdo_oe <= 1'b1;
    else if (data_done & rd & ~mb) sdo_oe <= 1'b0;
  end
  assign o_spi_sdo_oe = sdo_oe;
`else
  assign o_spi_sdo_oe = o_busy;
`endif

endmodule

// File: tb/tb_gsensor_spi_responder.sv
`timescale 1ns/1ps
// Randomized bench for gsensor_spi_responder against a transaction-level register model.
module tb_gsensor_spi_responder;

  localparam logic [7:0] DEVID = 8'hE5;

  logic       clk = 1'b0;
  logic       rst, cs_n, sclk, sdi, sdo, sdo_oe, wr_en, rx_valid, busy;
  logic [5:0] wr_addr, rx_addr;
  logic [7:0] wr_data, rx_data;

  gsensor_spi_responder dut (
    .i_clk(clk), .i_rst(rst), .i_spi_cs_n(cs_n), .i_spi_sclk(sclk), .i_spi_sdi(sdi),
    .o_spi_sdo(sdo), .o_spi_sdo_oe(sdo_oe), .i_reg_wr_en(wr_en), .i_reg_wr_addr(wr_addr),
    .i_reg_wr_data(wr_data), .o_rx_valid(rx_valid), .o_rx_addr(rx_addr), .o_rx_data(rx_data),
    .o_busy(busy)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          half = 6;
  logic [7:0]  mdl [64];
  logic [7:0]  tx_buf [80];
  logic [7:0]  rx_buf [80];
  logic [7:0]  exp_miso [80];
  logic [13:0] rx_q [$];
  logic [13:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) if (rx_valid === 1'b1) rx_q.push_back({rx_addr, rx_data});

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = (i == 0) ? DEVID : 8'h00;
  endtask

  task automatic model_txn(input int n);
    logic rd_m, mb_m;
    logic [5:0] a;
    rd_m = tx_buf[0][7];
    mb_m = tx_buf[0][6];
    a    = tx_buf[0][5:0];
    exp_miso[0] = 8'h00;
    for (int i = 1; i < n; i++) begin
      exp_miso[i] = 8'h00;
      if (!mb_m && i > 1) continue;
      if (rd_m) exp_miso[i] = mdl[a];
      else if (a != 6'd0) begin
        mdl[a] = tx_buf[i];
        exp_q.push_back({a, tx_buf[i]});
      end
      a = a + 6'd1;
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    sclk = 1'b0;
    sdi  = b;
    repeat (half) @(negedge clk);
    m    = sdo;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nb);
    logic m;
    for (int b = 7; b > 7 - nb; b--) spi_bit(v[b], m);
  endtask

  task automatic spi_xfer(input int n);
    logic m;
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--) begin
        spi_bit(tx_buf[i][b], m);
        rx_buf[i][b] = m;
      end
    cs_n = 1'b1;
    repeat (2 * half) @(negedge clk);
  endtask

  task automatic compare_txn(input string tag, input int n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s_miso%0d", tag, i), {24'd0, rx_buf[i]}, {24'd0, exp_miso[i]});
    check_eq({tag, "_nrx"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_rx"}, {18'd0, rx_q.pop_front()}, {18'd0, exp_q.pop_front()});
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn(input string tag, input int n);
    model_txn(n);
    spi_xfer(n);
    compare_txn(tag, n);
  endtask

  task automatic fab_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a != 6'd0) mdl[a] = d;
  endtask

  task automatic dump(input string tag);
    tx_buf[0] = 8'hC0;
    for (int i = 1; i <= 64; i++) tx_buf[i] = 8'h00;
    run_txn(tag, 65);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    int   n;
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; sdi = 1'b0;
    wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_out", {14'd0, sdo, sdo_oe, rx_valid, busy, rx_addr, rx_data}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    model_reset();
    dump("reset_dump");

    tx_buf[0] = 8'h2D; tx_buf[1] = 8'h08; run_txn("wr2d", 2);
    tx_buf[0] = 8'hAD; tx_buf[1] = 8'h00; run_txn("rd2d", 2);

    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; run_txn("devid", 2);
    tx_buf[0] = 8'h00; tx_buf[1] = 8'h55; run_txn("wr00", 2);
    tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; run_txn("devid2", 2);

    for (int i = 0; i < 6; i++) fab_wr(6'h32 + 6'(i), 8'h11 * 8'(i + 1));
    tx_buf[0] = 8'hF2;
    for (int i = 1; i < 7; i++) tx_buf[i] = 8'h00;
    run_txn("mb_rd", 7);

    tx_buf[0] = 8'h7F; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB; run_txn("wrap1", 3);
    tx_buf[0] = 8'h7E; tx_buf[1] = 8'hCC; tx_buf[2] = 8'hDD; run_txn("wrap2", 3);

    // abort after 5 data bits
    fab_wr(6'h20, 8'h5A);
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    spi_bits(8'h20, 8);
    check_eq("frame_busy", {31'd0, busy}, 32'd1);
`ifdef GSENSOR_SPI_3WIRE_EN
    check_eq("frame_oe", {31'd0, sdo_oe}, 32'd0);
`else
    check_eq("frame_oe", {31'd0, sdo_oe}, 32'd1);
`endif
    spi_bits(8'hFF, 5);
    cs_n = 1'b1;
    repeat (2 * half) @(negedge clk);
    check_eq("abort_nrx", rx_q.size(), 0);
    rx_q.delete();
    tx_buf[0] = 8'hA0; tx_buf[1] = 8'h00; run_txn("abort_rd", 2);

    // fabric write held on 0x1E until the SPI commit lands on the same edge
    tx_buf[0] = 8'h1E; tx_buf[1] = 8'h7F;
    model_txn(2);
    fork
      spi_xfer(2);
      begin
        wr_addr = 6'h1E; wr_data = 8'h01; wr_en = 1'b1; seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
          @(negedge clk);
          if (rx_valid) seen = 1'b1;
        end
        wr_en = 1'b0;
        check_eq("coll_seen", {31'd0, seen}, 32'd1);
      end
    join
    compare_txn("coll", 2);
    tx_buf[0] = 8'h9E; tx_buf[1] = 8'h00; run_txn("coll_rd", 2);

    for (int k = 0; k < 25; k++) begin
      half = $urandom_range(5, 8);
      if ($urandom_range(0, 2) == 0) fab_wr(6'($urandom), 8'($urandom));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      run_txn($sformatf("rnd%0d", k), n);
    end

    // reset in the middle of a read, then a write-looking remainder in the same frame
    half = 6;
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    spi_bits(8'hC0, 8);
    spi_bits(8'h00, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_out", {14'd0, sdo, sdo_oe, rx_valid, busy, rx_addr, rx_data}, 32'd0);
    rst = 1'b0;
    repeat (half) @(negedge clk);
    spi_bits(8'h2A, 8);
    check_eq("midrst_busy", {31'd0, busy}, 32'd1);
    spi_bits(8'h33, 8);
    cs_n = 1'b1;
    repeat (2 * half) @(negedge clk);
    check_eq("midrst_nrx", rx_q.size(), 0);
    rx_q.delete();
    model_reset();
    dump("post_rst_dump");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
